// File: rtl/fifo_flex_if.sv
// fifo_flex_if: handshake and status bundle for the fifo_flex synchronous FIFO.
// The producer/consumer side uses the master modport; the FIFO itself uses slave.
// max_count only carries a live value when FIFO_FLEX_WATERMARK_EN is defined.
interface fifo_flex_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic                  write;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  read;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  empty;
  logic                  full;
  logic [ADDR_WIDTH:0]   count;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;
  logic                  clr_err;
  logic [ADDR_WIDTH:0]   max_count;

  modport master (
    output write, wdata, read, clr_err,
    input  rdata, empty, full, count, almost_full, almost_empty,
           overflow, underflow, max_count
  );

  modport slave (
    input  write, wdata, read, clr_err,
    output rdata, empty, full, count, almost_full, almost_empty,
           overflow, underflow, max_count
  );
endinterface

// File: rtl/fifo_flex.sv
// fifo_flex: parametrised single-clock FIFO with show-ahead read data,
// occupancy count, programmable almost-full/almost-empty flags and sticky
// overflow/underflow error flags.
// Optional feature: define FIFO_FLEX_WATERMARK_EN to build the high-water mark
// register behind max_count; without it max_count is tied to zero.
module fifo_flex #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int ADDR_WIDTH    = $clog2(DEPTH),
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic         clk,
  input  logic         rst,
  fifo_flex_if.slave   bus
);
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_next;
  logic                  overflow;
  logic                  underflow;
  logic                  empty;
  logic                  full;
  logic                  wr_ok;
  logic                  rd_ok;

  // Status decodes come from the registered count only, so they never
  // depend on the request inputs of the current cycle.
  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  // A write into a full FIFO is still accepted when a read frees the head
  // slot on the same edge; reads are only ever refused when empty.
  assign wr_ok = bus.write & (~full | bus.read);
  assign rd_ok = bus.read & ~empty;

  // Next occupancy: a simultaneous accepted write and read cancel out.
  always_comb begin
    count_next = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Storage array; not reset, stale contents are never exposed as valid data.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[waddr] <= bus.wdata;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      waddr <= '0;
      raddr <= '0;
      count <= '0;
    end else begin
      if (wr_ok) waddr <= waddr + ADDR_WIDTH'(1);
      if (rd_ok) raddr <= raddr + ADDR_WIDTH'(1);
      count <= count_next;
    end
  end

  // Sticky error flags; a fresh error in the same cycle as clr_err wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (bus.write & ~wr_ok)  overflow <= 1'b1;
      else if (bus.clr_err)    overflow <= 1'b0;
      if (bus.read & ~rd_ok)   underflow <= 1'b1;
      else if (bus.clr_err)    underflow <= 1'b0;
    end
  end

`ifdef FIFO_FLEX_WATERMARK_EN
  logic [CNT_W-1:0] max_q;

  // High-water mark: restarts from the present occupancy on clr_err,
  // otherwise follows any new peak in occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= '0;
    end else if (bus.clr_err) begin
      max_q <= count;
    end else if (count_next > max_q) begin
      max_q <= count_next;
    end
  end

  assign bus.max_count = max_q;
`else
  assign bus.max_count = '0;
`endif

  assign bus.rdata        = mem[raddr];
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.count        = count;
  assign bus.almost_full  = (count >= AFULL_C);
  assign bus.almost_empty = (count <= AEMPTY_C);
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;
endmodule
